vend_remote_tx: RTL and testbench

- Remote-panel command transmitter: the initiator that drives the vending machine's UART command receiver.
- Converts single-cycle button pulses (quarter, dime, confirm) into ASCII command bytes.
- Buffers bytes in a small FIFO and serializes them as 8N1 UART frames on UART_TX.
- Sits on the remote board, after the button_pulse debouncers, wired to the vending machine's UART_RX.

---
 rtl/vend_remote_tx.sv | 195 +++++++++++++++++++
 tb/tb_vend_remote_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_remote_tx.sv
// vend_remote_tx: remote-panel command transmitter.
// Turns single-cycle button pulses (quarter, dime, confirm) into ASCII command
// bytes, buffers them in a small FIFO and sends them as 8N1 UART frames.
// Optional build macro VEND_TX_SELECT_EN: confirm enqueues 'C' followed by the
// ASCII digit of select_switch as an atomic pair.
module vend_remote_tx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          quarter_pulse,
  input  logic                          dime_pulse,
  input  logic                          confirm_pulse,
  input  logic [2:0]                    select_switch,
  output logic                          UART_TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_cnt
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_FW       = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [7:0] CMD_QUARTER = 8'h51;
  localparam logic [7:0] CMD_DIME    = 8'h44;
  localparam logic [7:0] CMD_CONFIRM = 8'h43;

  logic [1:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             bit_end;
  logic             pop;
  logic [CNT_FW:0]  free_slots;
  logic [1:0]       n_pulses;
  logic [1:0]       push_n;
  logic [7:0]       push_b0;
  logic [1:0]       drop_inc;
  logic [8:0]       drop_sum;

`ifdef VEND_TX_SELECT_EN
  logic [7:0]       push_b1;
`else
  logic             unused_select;
  assign unused_select = ^select_switch;
`endif

  assign bit_end    = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  // The transmitter takes the FIFO head when idle or at the very end of a stop bit.
  assign pop        = (fifo_count != '0) &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign free_slots = (CNT_FW+1)'(FIFO_DEPTH) - {1'b0, fifo_count} + (CNT_FW+1)'(pop);
  assign n_pulses   = {1'b0, quarter_pulse} + {1'b0, dime_pulse} + {1'b0, confirm_pulse};
  assign busy       = (state != ST_IDLE) || (fifo_count != '0);
  assign drop_sum   = {1'b0, drop_cnt} + {7'd0, drop_inc};

  // Pick the winning command (confirm > quarter > dime) and count the losers.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    push_n   = 2'd0;
    push_b0  = 8'h00;
    drop_inc = 2'd0;
`ifdef VEND_TX_SELECT_EN
    push_b1  = 8'h00;
`endif
    if (n_pulses != 2'd0) begin
      drop_inc = n_pulses - 2'd1;
`ifdef VEND_TX_SELECT_EN
      if (confirm_pulse) begin
        if (free_slots >= (CNT_FW+1)'(2)) begin
          push_n  = 2'd2;
          push_b0 = CMD_CONFIRM;
          push_b1 = {5'b00110, select_switch};
        end else begin
          drop_inc = drop_inc + 2'd1;
        end
      end else
`endif
      begin
        if (confirm_pulse)      push_b0 = CMD_CONFIRM;
        else if (quarter_pulse) push_b0 = CMD_QUARTER;
        else                    push_b0 = CMD_DIME;
        if (free_slots != '0) push_n   = 2'd1;
        else                  drop_inc = drop_inc + 2'd1;
      end
    end
  end

  // FIFO storage: data only, occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately left out of reset; the count marks what is valid.
    if (push_n != 2'd0) mem[wr_ptr] <= push_b0;
`ifdef VEND_TX_SELECT_EN
    if (push_n == 2'd2) mem[wr_ptr + PTR_W'(1)] <= push_b1;
`endif
  end

  // FIFO pointers, occupancy and the saturating drop counter.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_cnt   <= 8'd0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(push_n);
      rd_ptr     <= rd_ptr + PTR_W'(pop);
      fifo_count <= fifo_count + CNT_FW'(push_n) - CNT_FW'(pop);
      drop_cnt   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // UART framing FSM: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      UART_TX  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          UART_TX  <= 1'b1;
          if (pop) begin
            shreg   <= mem[rd_ptr];
            UART_TX <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            UART_TX  <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              UART_TX <= 1'b1;
              state   <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              UART_TX <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg   <= mem[rd_ptr];
              UART_TX <= 1'b0;
              state   <= ST_START;
            end else begin
              state   <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          UART_TX <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_remote_tx.sv
// tb_vend_remote_tx: scoreboard bench for vend_remote_tx at 16 clocks per bit.
// A frame-level reference model predicts line level, busy, occupancy and drops
// every cycle and queues expected bytes; a separate monitor decodes frames.
module tb_vend_remote_tx;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DEPTH    = 4;
  localparam int C        = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       quarter_pulse = 1'b0;
  logic       dime_pulse = 1'b0;
  logic       confirm_pulse = 1'b0;
  logic [2:0] select_switch = 3'd0;
  logic       UART_TX;
  logic       busy;
  logic [2:0] fifo_count;
  logic [7:0] drop_cnt;

  vend_remote_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .quarter_pulse(quarter_pulse), .dime_pulse(dime_pulse),
    .confirm_pulse(confirm_pulse), .select_switch(select_switch),
    .UART_TX(UART_TX), .busy(busy), .fifo_count(fifo_count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: queued bytes, cycles left in the current frame, byte on the line.
  logic [7:0] model_fifo[$];
  logic [7:0] exp_q[$];
  int         m_rem = 0;
  logic [7:0] m_cur = 8'h00;
  int         m_drop = 0;
  bit         armed = 1'b0;

  function automatic logic exp_line();
    int slot;
    if (m_rem == 0) return 1'b1;
    slot = (FRAME - m_rem) / C;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_cur[slot-1];
  endfunction

  // Compare the DUT against the model, then advance the model by the coming edge.
  always @(negedge clk) begin : model
    int npl, inc, free;
    bit pop;
    logic [7:0] add[$];
    if (armed) begin
      check("uart_tx", 32'(UART_TX), 32'(exp_line()));
      check("busy", 32'(busy), 32'((m_rem != 0) || (model_fifo.size() != 0)));
      check("fifo_count", 32'(fifo_count), 32'(model_fifo.size()));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
    if (reset) begin
      model_fifo.delete();
      exp_q.delete();
      m_rem  = 0;
      m_drop = 0;
      armed  = 1'b1;
    end else if (armed) begin
      add.delete();
      npl  = int'(quarter_pulse) + int'(dime_pulse) + int'(confirm_pulse);
      inc  = 0;
      pop  = (m_rem <= 1) && (model_fifo.size() > 0);
      free = DEPTH - model_fifo.size() + int'(pop);
      if (npl > 0) begin
        inc = npl - 1;
`ifdef VEND_TX_SELECT_EN
        if (confirm_pulse) begin
          if (free >= 2) begin
            add.push_back(8'h43);
            add.push_back(8'h30 + 8'(select_switch));
          end else begin
            inc++;
          end
        end else
`endif
        begin
          if (free >= 1) begin
            if (confirm_pulse)      add.push_back(8'h43);
            else if (quarter_pulse) add.push_back(8'h51);
            else                    add.push_back(8'h44);
          end else begin
            inc++;
          end
        end
      end
      m_drop = (m_drop + inc > 255) ? 255 : m_drop + inc;
      if (pop) begin
        m_cur = model_fifo.pop_front();
        m_rem = FRAME;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      foreach (add[i]) begin
        model_fifo.push_back(add[i]);
        exp_q.push_back(add[i]);
      end
    end
  end

  // Monitor: decode frames from the line mid-bit and score them against the queue.
  bit         in_frame = 1'b0;
  int         mcnt = 0;
  logic       prev_tx = 1'b1;
  logic [7:0] rx = 8'h00;

  always @(negedge clk) begin : monitor
    int k;
    if (reset) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (prev_tx === 1'b1 && UART_TX === 1'b0) begin
        in_frame = 1'b1;
        mcnt     = 0;
      end
    end else begin
      mcnt++;
    end
    if (in_frame && (mcnt % C == C / 2)) begin
      k = mcnt / C;
      if (k == 0) begin
        check("start_bit", 32'(UART_TX), 32'd0);
      end else if (k <= 8) begin
        rx[k-1] = UART_TX;
      end else begin
        check("stop_bit", 32'(UART_TX), 32'd1);
        if (exp_q.size() == 0) check("frame_unexpected", 32'(rx), 32'h100);
        else                   check("frame_byte", 32'(rx), 32'(exp_q.pop_front()));
        frames++;
        in_frame = 1'b0;
      end
    end
    prev_tx = UART_TX;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic q, input logic d, input logic c, input logic [2:0] sel);
    quarter_pulse = q;
    dime_pulse    = d;
    confirm_pulse = c;
    select_switch = sel;
    tick(1);
    quarter_pulse = 1'b0;
    dime_pulse    = 1'b0;
    confirm_pulse = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (busy !== 1'b0 || fifo_count !== 3'd0); i++) tick(1);
    check("idle_within_budget", 32'(busy), 32'd0);
    tick(2);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int frames_before;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("reset_tx", 32'(UART_TX), 32'd1);
    check("reset_drop", 32'(drop_cnt), 32'd0);

    // Single quarter.
    pulse(1'b1, 1'b0, 1'b0, 3'd0);
    wait_idle(400);
    check("single_frames", 32'(frames), 32'd1);

    // Dime, confirm, quarter on consecutive cycles.
    pulse(1'b0, 1'b1, 1'b0, 3'd0);
    pulse(1'b0, 1'b0, 1'b1, 3'd5);
    pulse(1'b1, 1'b0, 1'b0, 3'd0);
    wait_idle(1200);

    // Quarter and dime together: dime loses.
    pulse(1'b1, 1'b1, 1'b0, 3'd0);
    wait_idle(400);
    check("collision_drop", 32'(drop_cnt), 32'd1);

    // Six quarters in a row into a 4-deep FIFO.
    quarter_pulse = 1'b1;
    tick(6);
    quarter_pulse = 1'b0;
    wait_idle(1200);
    check("overflow_drop", 32'(drop_cnt), 32'd2);

    // Reset 40 cycles into a frame with another command still queued.
    pulse(1'b0, 1'b1, 1'b0, 3'd0);
    pulse(1'b1, 1'b0, 1'b0, 3'd0);
    tick(40);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("abort_tx", 32'(UART_TX), 32'd1);
    check("abort_count", 32'(fifo_count), 32'd0);
    check("abort_drop", 32'(drop_cnt), 32'd0);
    frames_before = frames;
    tick(300);
    check("abort_no_frames", 32'(frames - frames_before), 32'd0);

`ifdef VEND_TX_SELECT_EN
    // Confirm pair with selection 5, then with only one slot free.
    pulse(1'b0, 1'b0, 1'b1, 3'd5);
    wait_idle(800);
    quarter_pulse = 1'b1;
    tick(4);
    quarter_pulse = 1'b0;
    pulse(1'b0, 1'b0, 1'b1, 3'd2);
    check("pair_full_drop", 32'(drop_cnt), 32'd1);
    wait_idle(1200);
`endif

    // Hammer all buttons to saturate the drop counter.
    quarter_pulse = 1'b1;
    dime_pulse    = 1'b1;
    confirm_pulse = 1'b1;
    tick(140);
    quarter_pulse = 1'b0;
    dime_pulse    = 1'b0;
    confirm_pulse = 1'b0;
    check("drop_saturated", 32'(drop_cnt), 32'd255);
    wait_idle(2000);

    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      quarter_pulse = ($urandom_range(0, 29) == 0);
      dime_pulse    = ($urandom_range(0, 29) == 0);
      confirm_pulse = ($urandom_range(0, 29) == 0);
      select_switch = 3'($urandom_range(0, 7));
      tick(1);
    end
    quarter_pulse = 1'b0;
    dime_pulse    = 1'b0;
    confirm_pulse = 1'b0;
    wait_idle(3000);
    tick(5);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
